// File: rtl/pipe_control.sv
// pipe_control: ID-stage decode, load-use / multiply stall and branch flush
// control, plus the ID/EX control register feeding the EX stage.
module pipe_control #(
  parameter int MUL_LAT    = 3,
  parameter int ENABLE_MUL = 1,
  parameter int RAW        = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           valid_i,
  input  logic [6:0]     Op_i,
  input  logic [6:0]     Funct7_i,
  input  logic [RAW-1:0] RS1addr_i,
  input  logic [RAW-1:0] RS2addr_i,
  input  logic [RAW-1:0] RDaddr_i,
  input  logic           BrTaken_i,
  output logic           Stall_o,
  output logic           Flush_o,
  output logic           Busy_o,
  output logic           EX_valid_o,
  output logic           EX_RegWrite_o,
  output logic           EX_MemtoReg_o,
  output logic           EX_MemRead_o,
  output logic           EX_MemWrite_o,
  output logic           EX_ALUSrc_o,
  output logic           EX_Mul_o,
  output logic [1:0]     EX_ALUOp_o,
  output logic [RAW-1:0] EX_RDaddr_o
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MULBUSY = 1'b1;

  // A single-cycle multiply never needs to hold the pipe.
  localparam logic       MUL_MULTI = (MUL_LAT > 1);
  localparam logic [3:0] CNT_LOAD  = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  logic [0:0] state;
  logic [3:0] cnt;

  logic           dec_valid, dec_rw, dec_m2r, dec_mr, dec_mw, dec_src, dec_mul;
  logic [1:0]     dec_aluop;
  logic [RAW-1:0] dec_rd;
  logic           is_r, is_st, is_br;
  logic           rs2_used, load_use, mul_ex, busy;

  // Combinational ID decode; an unknown opcode or empty slot decodes to nothing.
  always_comb begin
    dec_valid = 1'b0;
    dec_rw    = 1'b0;
    dec_m2r   = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_src   = 1'b0;
    dec_aluop = 2'b00;
    is_r      = 1'b0;
    is_st     = 1'b0;
    is_br     = 1'b0;
    if (valid_i) begin
      case (Op_i)
        OP_R:  begin dec_valid = 1'b1; is_r  = 1'b1; dec_rw = 1'b1; dec_aluop = 2'b10; end
        OP_I:  begin dec_valid = 1'b1; dec_rw = 1'b1; dec_aluop = 2'b11; dec_src = 1'b1; end
        OP_LD: begin
          dec_valid = 1'b1; dec_rw = 1'b1; dec_mr = 1'b1; dec_m2r = 1'b1; dec_src = 1'b1;
        end
        OP_ST: begin dec_valid = 1'b1; is_st = 1'b1; dec_mw = 1'b1; dec_src = 1'b1; end
        OP_BR: begin dec_valid = 1'b1; is_br = 1'b1; dec_aluop = 2'b01; end
        default: ;
      endcase
    end
  end

  assign dec_mul  = is_r && (Funct7_i == 7'b0000001) && (ENABLE_MUL != 0);
  assign dec_rd   = dec_valid ? RDaddr_i : '0;
  assign rs2_used = is_r || is_st || is_br;

  // rs1 is read by every decoded class; rs2 only by R, store and branch.
  assign load_use = EX_MemRead_o && (EX_RDaddr_o != '0) &&
                    ((dec_valid && (RS1addr_i == EX_RDaddr_o)) ||
                     (rs2_used  && (RS2addr_i == EX_RDaddr_o)));

  assign mul_ex = EX_valid_o && EX_Mul_o && MUL_MULTI;

  // The cycle the counter sits at zero is the multiply's last EX cycle, so the
  // hold is released there and the next instruction enters EX on that edge.
  // Without this a held multiply would re-trigger busy when back in IDLE.
  assign busy = ((state == MULBUSY) && (cnt != 4'd0)) ||
                ((state == IDLE) && mul_ex);

  assign Busy_o  = busy;
  assign Stall_o = busy || load_use;
  assign Flush_o = !rst_i && !Stall_o && is_br && BrTaken_i;

  // Multiply occupancy tracker.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: if (mul_ex) begin
          state <= MULBUSY;
          cnt   <= CNT_LOAD;
        end
        MULBUSY: if (cnt == 4'd0) state <= IDLE;
                 else             cnt   <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end

  // ID/EX register: hold while busy, bubble on load-use, else take the decode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      EX_valid_o    <= 1'b0;
      EX_RegWrite_o <= 1'b0;
      EX_MemtoReg_o <= 1'b0;
      EX_MemRead_o  <= 1'b0;
      EX_MemWrite_o <= 1'b0;
      EX_ALUSrc_o   <= 1'b0;
      EX_Mul_o      <= 1'b0;
      EX_ALUOp_o    <= 2'b00;
      EX_RDaddr_o   <= '0;
    end else if (busy) begin
      // hold
    end else if (load_use) begin
      EX_valid_o    <= 1'b0;
      EX_RegWrite_o <= 1'b0;
      EX_MemtoReg_o <= 1'b0;
      EX_MemRead_o  <= 1'b0;
      EX_MemWrite_o <= 1'b0;
      EX_ALUSrc_o   <= 1'b0;
      EX_Mul_o      <= 1'b0;
      EX_ALUOp_o    <= 2'b00;
      EX_RDaddr_o   <= '0;
    end else begin
      EX_valid_o    <= dec_valid;
      EX_RegWrite_o <= dec_rw;
      EX_MemtoReg_o <= dec_m2r;
      EX_MemRead_o  <= dec_mr;
      EX_MemWrite_o <= dec_mw;
      EX_ALUSrc_o   <= dec_src;
      EX_Mul_o      <= dec_mul;
      EX_ALUOp_o    <= dec_aluop;
      EX_RDaddr_o   <= dec_rd;
    end
  end

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: drives three configurations (MUL_LAT=3, MUL_LAT=1,
// ENABLE_MUL=0) with shared ID stimulus and compares every output each cycle
// against an occupancy-based reference model.
module tb_pipe_control;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] XX = 7'b1111111;

  typedef struct packed {
    logic v, rw, m2r, mr, mw, src, mul;
    logic [1:0] op;
    logic [4:0] rd;
  } ex_t;

  logic clk, rst, valid, brtaken;
  logic [6:0] op, f7;
  logic [4:0] rs1, rs2, rd;

  logic [2:0] stall, flush, busy, exv, exrw, exm2r, exmr, exmw, exsrc, exmul;
  logic [2:0][1:0] aluop;
  logic [2:0][4:0] exrd;

  int lat [3] = '{3, 1, 3};
  bit en  [3] = '{1'b1, 1'b1, 1'b0};

  ex_t mex [3];
  int  occ [3];
  int  busy_cnt [3];
  int  mul_cnt  [3];
  int  total = 0, bad = 0, cyc = 0;

  pipe_control #(.MUL_LAT(3), .ENABLE_MUL(1), .RAW(5)) dut0 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .Op_i(op), .Funct7_i(f7),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd), .BrTaken_i(brtaken),
    .Stall_o(stall[0]), .Flush_o(flush[0]), .Busy_o(busy[0]),
    .EX_valid_o(exv[0]), .EX_RegWrite_o(exrw[0]), .EX_MemtoReg_o(exm2r[0]),
    .EX_MemRead_o(exmr[0]), .EX_MemWrite_o(exmw[0]), .EX_ALUSrc_o(exsrc[0]),
    .EX_Mul_o(exmul[0]), .EX_ALUOp_o(aluop[0]), .EX_RDaddr_o(exrd[0]));

  pipe_control #(.MUL_LAT(1), .ENABLE_MUL(1), .RAW(5)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .Op_i(op), .Funct7_i(f7),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd), .BrTaken_i(brtaken),
    .Stall_o(stall[1]), .Flush_o(flush[1]), .Busy_o(busy[1]),
    .EX_valid_o(exv[1]), .EX_RegWrite_o(exrw[1]), .EX_MemtoReg_o(exm2r[1]),
    .EX_MemRead_o(exmr[1]), .EX_MemWrite_o(exmw[1]), .EX_ALUSrc_o(exsrc[1]),
    .EX_Mul_o(exmul[1]), .EX_ALUOp_o(aluop[1]), .EX_RDaddr_o(exrd[1]));

  pipe_control #(.MUL_LAT(3), .ENABLE_MUL(0), .RAW(5)) dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .Op_i(op), .Funct7_i(f7),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd), .BrTaken_i(brtaken),
    .Stall_o(stall[2]), .Flush_o(flush[2]), .Busy_o(busy[2]),
    .EX_valid_o(exv[2]), .EX_RegWrite_o(exrw[2]), .EX_MemtoReg_o(exm2r[2]),
    .EX_MemRead_o(exmr[2]), .EX_MemWrite_o(exmw[2]), .EX_ALUSrc_o(exsrc[2]),
    .EX_Mul_o(exmul[2]), .EX_ALUOp_o(aluop[2]), .EX_RDaddr_o(exrd[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode straight from the opcode table.
  function automatic ex_t decode(logic v, logic [6:0] o, logic [6:0] f, logic [4:0] d, bit men);
    ex_t e;
    e = '0;
    if (v) begin
      case (o)
        R:  begin e.v = 1; e.rw = 1; e.op = 2'b10; e.mul = men && (f == 7'b0000001); end
        I:  begin e.v = 1; e.rw = 1; e.op = 2'b11; e.src = 1; end
        LD: begin e.v = 1; e.rw = 1; e.mr = 1; e.m2r = 1; e.src = 1; end
        ST: begin e.v = 1; e.mw = 1; e.src = 1; end
        BR: begin e.v = 1; e.op = 2'b01; end
        default: ;
      endcase
      if (e.v) e.rd = d;
    end
    return e;
  endfunction

  function automatic logic [16:0] observed(int i);
    return {stall[i], flush[i], busy[i], exv[i], exrw[i], exm2r[i], exmr[i],
            exmw[i], exsrc[i], exmul[i], aluop[i], exrd[i]};
  endfunction

  task automatic chk(string tag, logic [16:0] o, logic [16:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mex[i] = '0;
      occ[i] = 1;
    end
  endfunction

  // One cycle: drive ID, check settled outputs before the edge, advance model.
  task automatic step(logic v, logic [6:0] o, logic [6:0] f, logic [4:0] a, logic [4:0] b,
                      logic [4:0] d, logic t);
    bit   st [3];
    bit   lu [3];
    bit   bu [3];
    ex_t  id [3];
    bit   u2;
    valid = v; op = o; f7 = f; rs1 = a; rs2 = b; rd = d; brtaken = t;
    #2;
    for (int i = 0; i < 3; i++) begin
      bit fl;
      id[i] = decode(v, o, f, d, en[i]);
      u2    = v && (o == R || o == ST || o == BR);
      bu[i] = mex[i].v && mex[i].mul && (occ[i] < lat[i]);
      lu[i] = mex[i].mr && (mex[i].rd != 0) &&
              ((id[i].v && a == mex[i].rd) || (u2 && b == mex[i].rd));
      st[i] = bu[i] || lu[i];
      fl    = !st[i] && v && (o == BR) && t;
      chk($sformatf("cyc%0d_cfg%0d", cyc, i), observed(i), {st[i], fl, bu[i], mex[i]});
      chk($sformatf("excl_cyc%0d_cfg%0d", cyc, i), 17'(stall[i] & flush[i]), 17'd0);
      if (busy[i])  busy_cnt[i]++;
      if (exmul[i]) mul_cnt[i]++;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (bu[i])      occ[i]++;
      else if (lu[i]) begin mex[i] = '0;    occ[i] = 1; end
      else            begin mex[i] = id[i]; occ[i] = 1; end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic nop();
    step(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset(string tag);
    valid = 1'b0; brtaken = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("%s_cfg%0d", tag, i), observed(i), 17'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 0; op = 0; f7 = 0; rs1 = 0; rs2 = 0; rd = 0; brtaken = 0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_cfg%0d", i), observed(i), 17'd0);
    @(negedge clk);
    rst = 1'b0;

    // Plain R-type add.
    step(1, R, 7'h00, 5'd1, 5'd2, 5'd3, 0);
    chk("add_ex", 17'({exrw[0], aluop[0], exsrc[0], stall[0]}), 17'({1'b1, 2'b10, 1'b0, 1'b0}));
    nop();

    // Load to x5 then a dependent add (presented twice: held, then accepted).
    step(1, LD, 7'h00, 5'd1, 5'd0, 5'd5, 0);
    step(1, R,  7'h00, 5'd5, 5'd2, 5'd6, 0);
    step(1, R,  7'h00, 5'd5, 5'd2, 5'd6, 0);
    chk("lu_add_in_ex", 17'({exv[0], exrw[0], exrd[0]}), 17'({1'b1, 1'b1, 5'd6}));
    nop();
    // Same with rd=x0: no hazard.
    step(1, LD, 7'h00, 5'd1, 5'd0, 5'd0, 0);
    step(1, R,  7'h00, 5'd0, 5'd0, 5'd6, 0);
    nop();
    // rs2 of an I-type is not a real source.
    step(1, LD, 7'h00, 5'd1, 5'd0, 5'd7, 0);
    step(1, I,  7'h00, 5'd1, 5'd7, 5'd8, 0);
    nop();

    // Multiply occupancy across the three configurations.
    for (int i = 0; i < 3; i++) begin busy_cnt[i] = 0; mul_cnt[i] = 0; end
    step(1, R, 7'h01, 5'd1, 5'd2, 5'd9, 0);
    repeat (5) nop();
    chk("mul_busy_lat3", 17'(busy_cnt[0]), 17'd2);
    chk("mul_held_lat3", 17'(mul_cnt[0]),  17'd3);
    chk("mul_busy_lat1", 17'(busy_cnt[1]), 17'd0);
    chk("mul_busy_nomul", 17'(busy_cnt[2]), 17'd0);
    chk("mul_flag_nomul", 17'(mul_cnt[2]),  17'd0);

    // Taken branch: alone, behind a load-use, and behind a multiply.
    step(1, BR, 7'h00, 5'd1, 5'd2, 5'd0, 1);
    nop();
    step(1, LD, 7'h00, 5'd1, 5'd0, 5'd4, 0);
    step(1, BR, 7'h00, 5'd3, 5'd4, 5'd0, 1);
    step(1, BR, 7'h00, 5'd3, 5'd4, 5'd0, 1);
    step(1, R,  7'h01, 5'd1, 5'd2, 5'd3, 0);
    repeat (3) step(1, BR, 7'h00, 5'd1, 5'd2, 5'd0, 1);
    nop();

    // Unknown opcode decodes to nothing.
    step(1, XX, 7'h7f, 5'd1, 5'd2, 5'd3, 1);
    chk("bad_op_ex", observed(0), 17'd0);

    // Reset in the middle of a multiply, then a fresh instruction.
    step(1, R, 7'h01, 5'd1, 5'd2, 5'd3, 0);
    nop();
    async_reset("rst_mid_mul");
    step(1, I, 7'h00, 5'd1, 5'd2, 5'd3, 0);
    chk("post_rst_ex", 17'({exv[0], exrw[0], aluop[0], exsrc[0]}), 17'({1'b1, 1'b1, 2'b11, 1'b1}));

    // Random traffic with a small register range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] ops [7];
      logic [6:0] o, f;
      ops = '{R, I, LD, ST, BR, XX, 7'h00};
      o = ops[$urandom_range(0, 6)];
      if (o == 7'h00) o = 7'($urandom);
      f = ($urandom_range(0, 2) == 0) ? 7'h01 : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
      if ($urandom_range(0, 79) == 0) async_reset($sformatf("rst_rand%0d", n));
      step($urandom_range(0, 9) != 0, o, f, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
